// File: rtl/iter_barrel_shifter_if.sv
// Request/response bundle for iter_barrel_shifter.
// Defining SHIFT_STICKY_EN adds the `sticky` signal.
interface iter_barrel_shifter_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             busy;
`ifdef SHIFT_STICKY_EN
    logic             sticky;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, out, busy, sticky
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, out, busy, sticky
    );
`else
    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, out, busy
    );
`endif
endinterface

// File: rtl/iter_barrel_shifter.sv
// Multi-cycle LSL/LSR/ASR/ROL shifter moving up to STEP bits per clock, valid/ready on both sides.
// Define SHIFT_STICKY_EN to add the `sticky` output (OR of all bits shifted out).
module iter_barrel_shifter #(
    parameter int WIDTH = 16,
    parameter int STEP  = 4
) (
    input logic                  clk,
    input logic                  rst,
    iter_barrel_shifter_if.slave bus
);
    localparam int AW = $clog2(WIDTH);

    typedef logic [WIDTH-1:0] data_t;
    typedef logic [AW:0]      amt_t;

    localparam amt_t  STEP_A  = amt_t'(STEP);
    localparam amt_t  WIDTH_A = amt_t'(WIDTH);
    localparam data_t ONES    = '1;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROL = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_nx;
    data_t  work;
    amt_t   rem;
    mode_t  mode_q;

    logic   accept;
    amt_t   req_amt;
    data_t  src;
    mode_t  step_mode;
    amt_t   step_amt;
    amt_t   step_k;
    amt_t   step_rem;
    logic   step_last;
    data_t  step_res;

    // Large shift amounts saturate at WIDTH; ROL only needs the amount modulo WIDTH.
    always_comb begin : amount
        if (mode_t'(bus.mode) == ROL) begin
            req_amt = amt_t'(bus.b[AW-1:0]);
        end else if (bus.b >= data_t'(WIDTH)) begin
            req_amt = WIDTH_A;
        end else begin
            req_amt = amt_t'(bus.b);
        end
    end

    // The first step is applied on the accept edge itself, so amounts up to STEP finish
    // straight into DONE and the total latency is max(1, ceil(amt/STEP)).
    always_comb begin : step_unit
        if (state == IDLE) begin
            src       = bus.a;
            step_mode = mode_t'(bus.mode);
            step_amt  = req_amt;
        end else begin
            src       = work;
            step_mode = mode_q;
            step_amt  = rem;
        end

        step_k    = (step_amt > STEP_A) ? STEP_A : step_amt;
        step_rem  = step_amt - step_k;
        step_last = (step_amt <= STEP_A);

        case (step_mode)
            LSL:     step_res = src << step_k;
            LSR:     step_res = src >> step_k;
            ASR:     step_res = data_t'($signed(src) >>> step_k);
            ROL:     step_res = (src << step_k) | (src >> (WIDTH_A - step_k));
            default: step_res = src;
        endcase
    end

    always_comb begin : fsm_next
        state_nx      = state;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;

        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept   = 1'b1;
                    state_nx = step_last ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                bus.busy = 1'b1;
                if (step_last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state  <= IDLE;
            work   <= '0;
            rem    <= '0;
            mode_q <= LSL;
        end else begin
            state <= state_nx;
            if (accept || state == SHIFT) begin
                work <= step_res;
                rem  <= step_rem;
            end
            if (accept) begin
                mode_q <= mode_t'(bus.mode);
            end
        end
    end

    assign bus.out = work;

`ifdef SHIFT_STICKY_EN
    logic  sticky_q;
    logic  step_lost;
    data_t lo_mask;
    data_t hi_mask;

    // Bits leaving the register this step: low end for right shifts, high end for LSL.
    always_comb begin : sticky_unit
        lo_mask = ~(ONES << step_k);
        hi_mask = ~(ONES >> step_k);
        case (step_mode)
            LSL:      step_lost = |(src & hi_mask);
            LSR, ASR: step_lost = |(src & lo_mask);
            default:  step_lost = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin : sticky_reg
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (accept) begin
            sticky_q <= step_lost;
        end else if (state == SHIFT) begin
            sticky_q <= sticky_q | step_lost;
        end
    end

    assign bus.sticky = sticky_q;
`endif

endmodule

// File: tb/tb_iter_barrel_shifter.sv
// Scoreboard bench for iter_barrel_shifter (WIDTH=16, STEP=4): driver queues expected
// results and latencies, an independent monitor checks every delivered result.
module tb_iter_barrel_shifter;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] out;
        int           lat;
        logic         stk;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    int   n_sent = 0;
    int   n_got = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    iter_barrel_shifter_if #(.WIDTH(W)) bus ();

    iter_barrel_shifter #(.WIDTH(W), .STEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one request; when track is set the expected result is queued at the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m,
                        input logic [W-1:0] eo, input int lat, input logic stk, input bit track);
        exp_t e;
        int   g;
        @(posedge clk);
        #1;
        bus.a        = a;
        bus.b        = b;
        bus.mode     = m;
        bus.in_valid = 1'b1;
        g = 0;
        @(negedge clk);
        while (!bus.in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.b        = ~b;
        bus.mode     = ~m;
        if (track) begin
            e.out = eo;
            e.lat = lat;
            e.stk = stk;
            e.acc = cycle;
            q.push_back(e);
            n_sent++;
        end
    endtask

    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.out_valid && !prev) begin
                if (q.size() == 0)
                    chk("valid_without_request", q.size(), 1);
                else
                    chk($sformatf("latency_%0d", n_got), cycle - q[0].acc + 1, q[0].lat);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("result_without_request", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("out_%0d", n_got), bus.out, e.out);
`ifdef SHIFT_STICKY_EN
                    chk($sformatf("sticky_%0d", n_got), bus.sticky, e.stk);
`endif
                    n_got++;
                end
            end
            prev = bus.out_valid;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int g;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.mode      = 2'b00;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out", bus.out, 0);
`ifdef SHIFT_STICKY_EN
        chk("rst_sticky", bus.sticky, 0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // a, b, mode(0 LSL,1 LSR,2 ASR,3 ROL), expected out, latency, sticky
        send(16'h0001, 16'd1,     2'd0, 16'h0002, 1, 1'b0, 1'b1);
        send(16'h0001, 16'd15,    2'd0, 16'h8000, 4, 1'b0, 1'b1);
        send(16'h0001, 16'd2,     2'd0, 16'h0004, 1, 1'b0, 1'b1);
        send(16'h8000, 16'd4,     2'd2, 16'hF800, 1, 1'b0, 1'b1);
        send(16'h8000, 16'd4,     2'd1, 16'h0800, 1, 1'b0, 1'b1);
        send(16'h8000, 16'h0020,  2'd2, 16'hFFFF, 4, 1'b1, 1'b1);
        send(16'h1234, 16'd20,    2'd3, 16'h2341, 1, 1'b0, 1'b1);
        send(16'hFFFF, 16'hFFFF,  2'd0, 16'h0000, 4, 1'b1, 1'b1);
        send(16'h8001, 16'd5,     2'd3, 16'h0030, 2, 1'b0, 1'b1);
        send(16'hF0F0, 16'd9,     2'd1, 16'h0078, 3, 1'b1, 1'b1);
        send(16'h4000, 16'd16,    2'd2, 16'h0000, 4, 1'b1, 1'b1);
        send(16'h9000, 16'd6,     2'd2, 16'hFE40, 2, 1'b0, 1'b1);
        send(16'h1234, 16'd16,    2'd0, 16'h0000, 4, 1'b1, 1'b1);
        send(16'hBEEF, 16'd16,    2'd3, 16'hBEEF, 1, 1'b0, 1'b1);
        send(16'h0003, 16'd1,     2'd1, 16'h0001, 1, 1'b1, 1'b1);
        send(16'h0010, 16'd4,     2'd1, 16'h0001, 1, 1'b0, 1'b1);
        send(16'h8000, 16'd1,     2'd0, 16'h0000, 1, 1'b1, 1'b1);

        // Backpressure: result must hold while stray requests are ignored.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        send(16'hA5A5, 16'd0, 2'd0, 16'hA5A5, 1, 1'b0, 1'b1);
        g = 0;
        @(negedge clk);
        while (!bus.out_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("bp_valid", bus.out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.a        = 16'h1111 * 16'(i + 1);
            bus.b        = 16'(i + 3);
            bus.mode     = 2'(i);
            @(negedge clk);
            chk($sformatf("bp_out_%0d", i), bus.out, 16'hA5A5);
            chk($sformatf("bp_out_valid_%0d", i), bus.out_valid, 1);
            chk($sformatf("bp_in_ready_%0d", i), bus.in_ready, 0);
            chk($sformatf("bp_busy_%0d", i), bus.busy, 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("consume_in_ready", bus.in_ready, 0);
        @(negedge clk);
        chk("after_consume_in_ready", bus.in_ready, 1);
        chk("after_consume_out_valid", bus.out_valid, 0);

        // Reset in the middle of a long shift aborts it without a result.
        send(16'h0001, 16'd15, 2'd0, 16'h8000, 4, 1'b0, 1'b0);
        @(negedge clk);
        chk("abort_busy", bus.busy, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_out", bus.out, 0);
        chk("abort_busy_clear", bus.busy, 0);
        send(16'h0F00, 16'd8, 2'd1, 16'h000F, 2, 1'b0, 1'b1);

        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("result_count", n_got, n_sent);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
